// File: rtl/addsub_pkg.sv
// addsub_pkg: mode encodings and default geometry shared by the addsub_pipe slice.
package addsub_pkg;
  typedef enum logic {MODE_ADD = 1'b0, MODE_SUB = 1'b1} mode_e;
  localparam int ADDSUB_WIDTH = 32;
  localparam int ADDSUB_CHUNK = 8;
endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: combinational CHUNK-bit slice adder, one per pipeline stage.
module addsub_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/subtract, one CHUNK slice resolved per stage, valid/ready on both sides.
// Define ADDSUB_FLAGS_EN to add the V (signed overflow) and ZERO outputs.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int CHUNK = ADDSUB_CHUNK
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_IN,
  input  logic             MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             C_OUT
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             V,
  output logic             ZERO
`endif
);
  localparam int S = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  if (CHUNK <= 0 || WIDTH % ((CHUNK > 0) ? CHUNK : 1) != 0) begin : g_bad_cfg
    $error("addsub_pipe: WIDTH must be a nonzero multiple of CHUNK");
  end
  logic             en;
  logic [S-1:0]     vld_q, c_q, v_d, c_d, co;
  logic [WIDTH-1:0] a_q [S];
  logic [WIDTH-1:0] b_q [S];
  logic [WIDTH-1:0] z_q [S];
  logic [WIDTH-1:0] a_d [S];
  logic [WIDTH-1:0] b_d [S];
  logic [WIDTH-1:0] z_in [S];
  logic [WIDTH-1:0] z_d [S];
  logic [CHUNK-1:0] s [S];
  assign en        = !vld_q[S-1] || OUT_READY;
  assign IN_READY  = en;
  assign OUT_VALID = vld_q[S-1];
  assign Z         = z_q[S-1];
  assign C_OUT     = c_q[S-1];
  for (genvar k = 0; k < S; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_d[k]  = IN_VALID;
      assign a_d[k]  = X;
      assign b_d[k]  = (MODE == MODE_SUB) ? ~Y : Y;
      assign c_d[k]  = (MODE == MODE_SUB) ? ~C_IN : C_IN;
      assign z_in[k] = '0;
    end else begin : g_body
      assign v_d[k]  = vld_q[k-1];
      assign a_d[k]  = a_q[k-1];
      assign b_d[k]  = b_q[k-1];
      assign c_d[k]  = c_q[k-1];
      assign z_in[k] = z_q[k-1];
    end
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i   (a_d[k][k*CHUNK +: CHUNK]),
      .b_i   (b_d[k][k*CHUNK +: CHUNK]),
      .cin_i (c_d[k]),
      .sum_o (s[k]),
      .cout_o(co[k])
    );
    // Slices at and above k are still zero in the travelling result, so OR-ing in is enough.
    assign z_d[k] = z_in[k] | (WIDTH'(s[k]) << (k * CHUNK));
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int i = 0; i < S; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        z_q[i] <= '0;
      end
    end else if (en) begin
      vld_q <= v_d;
      c_q   <= co;
      for (int i = 0; i < S; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        z_q[i] <= z_d[i];
      end
    end
`ifdef ADDSUB_FLAGS_EN
  logic v_q, zero_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      v_q    <= 1'b0;
      zero_q <= 1'b0;
    end else if (en) begin
      v_q    <= (a_d[S-1][WIDTH-1] == b_d[S-1][WIDTH-1]) && (z_d[S-1][WIDTH-1] != a_d[S-1][WIDTH-1]);
      zero_q <= z_d[S-1] == '0;
    end
  assign V    = v_q;
  assign ZERO = zero_q;
`endif
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe with directed vectors, stall and mid-flight reset.
`timescale 1ns/1ps
module tb_addsub_pipe;
  localparam int W  = 32;
  localparam int CH = 8;
  localparam int S  = W / CH;
  typedef struct {
    logic [W-1:0] x, y;
    logic         ci, m;
    logic [W-1:0] z;
    logic         c, v, zr;
  } vec_t;
  typedef struct {
    logic [W-1:0] z;
    logic         c, v, zr;
    int           acc;
    bit           lat;
  } exp_t;
  logic         CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, C_IN = 1'b0, MODE = 1'b0, OUT_READY = 1'b1;
  logic         IN_READY, OUT_VALID, C_OUT;
  logic [W-1:0] X = '0, Y = '0, Z;
`ifdef ADDSUB_FLAGS_EN
  logic         V, ZERO;
`endif
  vec_t         tbl [13];
  exp_t         q [$];
  exp_t         e_cur, e_acc, e_mon;
  int           checks = 0, fails = 0, cyc = 0, n_acc = 0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] hz;
  logic         hc;

  addsub_pipe #(.WIDTH(W), .CHUNK(CH)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .X        (X),
    .Y        (Y),
    .C_IN     (C_IN),
    .MODE     (MODE),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .Z        (Z),
    .C_OUT    (C_OUT)
`ifdef ADDSUB_FLAGS_EN
    ,
    .V        (V),
    .ZERO     (ZERO)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic send(input int i, input bit lat);
    int n0 = n_acc;
    X        = tbl[i].x;
    Y        = tbl[i].y;
    C_IN     = tbl[i].ci;
    MODE     = tbl[i].m;
    e_cur    = '{tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].zr, 0, lat};
    IN_VALID = 1'b1;
    for (int t = 0; t < 50 && n_acc == n0; t++) begin
      @(posedge CLK);
      #1;
    end
    if (n_acc == n0) check("accept_timeout", 0, 1);
    IN_VALID = 1'b0;
    X        = 32'hDEADBEEF;
    Y        = 32'h5A5A5A5A;
    C_IN     = ~C_IN;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      @(posedge CLK);
      #1;
    end
    check("drain_empty", W'(q.size()), 0);
  endtask

  // Scoreboard push: the beat's expected response is queued on the edge that accepts it.
  initial forever begin
    @(posedge CLK);
    if (!RST && IN_VALID && IN_READY) begin
      e_acc     = e_cur;
      e_acc.acc = cyc;
      q.push_back(e_acc);
      n_acc++;
    end
    cyc++;
  end

  initial forever begin
    @(negedge CLK);
    if (RST) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        check("stall_valid", OUT_VALID, 1);
        check("stall_z", Z, hz);
        check("stall_cout", C_OUT, hc);
      end
      if (OUT_VALID && !OUT_READY) begin
        check("in_ready_stall", IN_READY, 0);
        stall_prev = 1'b1;
        hz         = Z;
        hc         = C_OUT;
      end else stall_prev = 1'b0;
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e_mon = q.pop_front();
          check("z", Z, e_mon.z);
          check("c_out", C_OUT, e_mon.c);
`ifdef ADDSUB_FLAGS_EN
          check("v", V, e_mon.v);
          check("zero", ZERO, e_mon.zr);
`endif
          if (e_mon.lat) check("latency", cyc - e_mon.acc, S);
        end
      end
    end
  end

  initial begin
    tbl[0]  = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{32'h00000001, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000FFFF, 32'h00000000, 1'b1, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{32'h00000100, 32'h00000001, 1'b0, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_z", Z, 0);
    check("rst_cout", C_OUT, 0);
`ifdef ADDSUB_FLAGS_EN
    check("rst_v", V, 0);
    check("rst_zero", ZERO, 0);
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(i, 1'b1);
      drain();
    end
    for (int i = 5; i < 13; i++) send(i, 1'b1);
    drain();
    fork
      for (int i = 5; i < 13; i++) send(i, 1'b0);
      begin
        repeat (6) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 3; i++) send(i, 1'b1);
    @(posedge CLK);
    #1;
    check("pre_reset_valid", OUT_VALID, W'(S > 1));
    RST = 1'b1;
    q.delete();
    #1;
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_z", Z, 0);
    check("mid_rst_cout", C_OUT, 0);
    check("mid_rst_in_ready", IN_READY, 1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    send(3, 1'b1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
